saturn_rstk_ctrl: RTL and testbench

Return-stack controller for the Saturn core. It owns the 8-entry, 20-bit RSTK storage and its pointer, and sequences every access to it: it clears the stack after reset, and executes push, pop and combined push/pop (replace-top) requests from the instruction decoder on the phase-3 slot. It also services debugger read/write accesses in free cycles. It sits between the decoder/PC logic and the debugger port, replacing ad-hoc RSTK writes with a single arbitrated owner.

---
 rtl/saturn_rstk_ctrl.sv | 146 ++++++++++++++
 tb/tb_saturn_rstk_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_rstk_ctrl.sv
// rtl/saturn_rstk_ctrl.sv - Saturn return-stack controller (8 x 20-bit RSTK, pointer, debugger port)
//
// Ports:
//   i_clk, i_reset            core clock, synchronous active-high reset
//   i_clk_en, i_phases        core clock enable, one-hot phase (bit 3 = decoder slot)
//   i_bus_busy                bus stall, blocks decoder requests
//   i_push_req/i_push_val     decoder push
//   i_pop_req                 decoder pop
//   o_pop_val/o_pop_valid     popped value (held) and its one-cycle strobe
//   o_push_ack                one-cycle push-committed strobe
//   i_dbg_req/wr/ptr/wdata    debugger access (level request, held until ack)
//   o_dbg_rdata/o_dbg_ack     debugger read data and completion strobe
//   o_busy                    high whenever the controller is not in IDLE
//   o_rstk_ptr, o_depth       top-of-stack pointer and valid-entry count (0..8)
module saturn_rstk_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic        i_bus_busy,
    input  logic        i_push_req,
    input  logic [19:0] i_push_val,
    input  logic        i_pop_req,
    output logic [19:0] o_pop_val,
    output logic        o_pop_valid,
    output logic        o_push_ack,
    input  logic        i_dbg_req,
    input  logic        i_dbg_wr,
    input  logic [2:0]  i_dbg_ptr,
    input  logic [19:0] i_dbg_wdata,
    output logic [19:0] o_dbg_rdata,
    output logic        o_dbg_ack,
    output logic        o_busy,
    output logic [2:0]  o_rstk_ptr,
    output logic [3:0]  o_depth
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_POP_CLR = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  ptr_q;
    logic [3:0]  depth_q;
    logic [19:0] rstk_q [8];
    logic [19:0] pop_val_q;
    logic        pop_valid_q;
    logic        push_ack_q;
    logic [19:0] dbg_rdata_q;
    logic        dbg_ack_q;

    logic        dslot;
    logic [2:0]  ptr_inc_d;
    logic [2:0]  ptr_dec_d;
    logic [3:0]  depth_inc_d;
    logic [3:0]  depth_dec_d;

    // Only phase 3 carries decoder requests; the other phase bits are unused here.
    logic unused_phases;
    assign unused_phases = &{1'b0, i_phases[2:0]};

    assign dslot       = (state_q == ST_IDLE) && i_clk_en && i_phases[3] && !i_bus_busy;
    assign ptr_inc_d   = ptr_q + 3'd1;
    assign ptr_dec_d   = ptr_q - 3'd1;
    // Depth saturates at both ends; the pointer wraps freely.
    assign depth_inc_d = (depth_q == 4'd8) ? 4'd8 : depth_q + 4'd1;
    assign depth_dec_d = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= 3'd0;
            ptr_q       <= 3'd7;
            depth_q     <= 4'd0;
            pop_val_q   <= 20'h00000;
            pop_valid_q <= 1'b0;
            push_ack_q  <= 1'b0;
            dbg_rdata_q <= 20'h00000;
            dbg_ack_q   <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            push_ack_q  <= 1'b0;
            dbg_ack_q   <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    // Free-running clear; does not wait for i_clk_en.
                    rstk_q[cnt_q] <= 20'h00000;
                    cnt_q         <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (dslot && i_push_req && i_pop_req) begin
                        // Replace-top: read and overwrite the same entry in one cycle.
                        pop_val_q     <= rstk_q[ptr_q];
                        rstk_q[ptr_q] <= i_push_val;
                        pop_valid_q   <= 1'b1;
                        push_ack_q    <= 1'b1;
                    end else if (dslot && i_push_req) begin
                        rstk_q[ptr_inc_d] <= i_push_val;
                        ptr_q             <= ptr_inc_d;
                        depth_q           <= depth_inc_d;
                        push_ack_q        <= 1'b1;
                    end else if (dslot && i_pop_req) begin
                        pop_val_q <= rstk_q[ptr_q];
                        state_q   <= ST_POP_CLR;
                    end else if (i_dbg_req) begin
                        // Debugger only gets cycles the decoder did not claim.
                        if (i_dbg_wr) begin
                            rstk_q[i_dbg_ptr] <= i_dbg_wdata;
                        end else begin
                            dbg_rdata_q <= rstk_q[i_dbg_ptr];
                        end
                        dbg_ack_q <= 1'b1;
                    end
                end
                ST_POP_CLR: begin
                    // Popped entries are zeroed so an underflow pop always returns 0.
                    rstk_q[ptr_q] <= 20'h00000;
                    ptr_q         <= ptr_dec_d;
                    depth_q       <= depth_dec_d;
                    pop_valid_q   <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign o_pop_val   = pop_val_q;
    assign o_pop_valid = pop_valid_q;
    assign o_push_ack  = push_ack_q;
    assign o_dbg_rdata = dbg_rdata_q;
    assign o_dbg_ack   = dbg_ack_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rstk_ptr  = ptr_q;
    assign o_depth     = depth_q;

endmodule

// File: tb/tb_saturn_rstk_ctrl.sv
// tb/tb_saturn_rstk_ctrl.sv - directed self-checking bench for saturn_rstk_ctrl
module tb_saturn_rstk_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [3:0]  phases;
    logic        bus_busy;
    logic        push_req;
    logic [19:0] push_val;
    logic        pop_req;
    logic [19:0] pop_val;
    logic        pop_valid;
    logic        push_ack;
    logic        dbg_req;
    logic        dbg_wr;
    logic [2:0]  dbg_ptr;
    logic [19:0] dbg_wdata;
    logic [19:0] dbg_rdata;
    logic        dbg_ack;
    logic        busy;
    logic [2:0]  rstk_ptr;
    logic [3:0]  depth;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    saturn_rstk_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clk_en    (clk_en),
        .i_phases    (phases),
        .i_bus_busy  (bus_busy),
        .i_push_req  (push_req),
        .i_push_val  (push_val),
        .i_pop_req   (pop_req),
        .o_pop_val   (pop_val),
        .o_pop_valid (pop_valid),
        .o_push_ack  (push_ack),
        .i_dbg_req   (dbg_req),
        .i_dbg_wr    (dbg_wr),
        .i_dbg_ptr   (dbg_ptr),
        .i_dbg_wdata (dbg_wdata),
        .o_dbg_rdata (dbg_rdata),
        .o_dbg_ack   (dbg_ack),
        .o_busy      (busy),
        .o_rstk_ptr  (rstk_ptr),
        .o_depth     (depth)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slot_on;
        clk_en = 1'b1;
        phases = 4'b1000;
    endtask

    task automatic slot_off;
        clk_en = 1'b0;
        phases = 4'b0001;
    endtask

    task automatic do_push(input logic [19:0] v, input logic [2:0] eptr, input logic [3:0] edepth);
        slot_on();
        push_req = 1'b1;
        push_val = v;
        tick();
        push_req = 1'b0;
        slot_off();
        chk("push_ack", {31'd0, push_ack}, 32'd1);
        chk("push_ptr", {29'd0, rstk_ptr}, {29'd0, eptr});
        chk("push_depth", {28'd0, depth}, {28'd0, edepth});
        tick();
        chk("push_ack_width", {31'd0, push_ack}, 32'd0);
    endtask

    task automatic do_pop(input logic [19:0] ev, input logic [2:0] eptr, input logic [3:0] edepth);
        slot_on();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        slot_off();
        chk("pop_busy", {31'd0, busy}, 32'd1);
        chk("pop_early_valid", {31'd0, pop_valid}, 32'd0);
        tick();
        chk("pop_valid", {31'd0, pop_valid}, 32'd1);
        chk("pop_val", {12'd0, pop_val}, {12'd0, ev});
        chk("pop_ptr", {29'd0, rstk_ptr}, {29'd0, eptr});
        chk("pop_depth", {28'd0, depth}, {28'd0, edepth});
        chk("pop_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("pop_valid_width", {31'd0, pop_valid}, 32'd0);
    endtask

    task automatic dbg_read(input logic [2:0] p, input logic [19:0] ev);
        dbg_req = 1'b1;
        dbg_wr  = 1'b0;
        dbg_ptr = p;
        tick();
        dbg_req = 1'b0;
        chk("dbg_rd_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg_rdata", {12'd0, dbg_rdata}, {12'd0, ev});
        tick();
        chk("dbg_ack_width", {31'd0, dbg_ack}, 32'd0);
    endtask

    task automatic init_check;
        for (int k = 1; k <= 8; k++) begin
            chk("init_busy", {31'd0, busy}, 32'd1);
            chk("init_no_pop", {31'd0, pop_valid}, 32'd0);
            tick();
        end
        chk("init_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; phases = 4'b0001; bus_busy = 1'b0;
        push_req = 1'b0; push_val = '0; pop_req = 1'b0;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_ptr = '0; dbg_wdata = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ptr", {29'd0, rstk_ptr}, 32'd7);
        chk("rst_depth", {28'd0, depth}, 32'd0);
        chk("rst_pop_val", {12'd0, pop_val}, 32'd0);
        chk("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        chk("rst_push_ack", {31'd0, push_ack}, 32'd0);
        chk("rst_dbg_rdata", {12'd0, dbg_rdata}, 32'd0);
        chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);

        reset = 1'b0;
        init_check();
        for (int e = 0; e < 8; e++) dbg_read(3'(e), 20'h00000);
        chk("post_init_ptr", {29'd0, rstk_ptr}, 32'd7);
        chk("post_init_depth", {28'd0, depth}, 32'd0);

        // Two pushes then two pops.
        do_push(20'h12345, 3'd0, 4'd1);
        do_push(20'hABCDE, 3'd1, 4'd2);
        do_pop(20'hABCDE, 3'd0, 4'd1);
        do_pop(20'h12345, 3'd7, 4'd0);
        dbg_read(3'd0, 20'h00000);
        dbg_read(3'd1, 20'h00000);

        // Nine pushes wrap the 8-entry stack; value 1 is overwritten by 9.
        for (int i = 1; i <= 9; i++)
            do_push(20'(i), 3'(i - 1), (i >= 8) ? 4'd8 : 4'(i));
        for (int i = 9; i >= 2; i--)
            do_pop(20'(i), 3'(i - 2), 4'(i - 2));
        do_pop(20'h00000, 3'd7, 4'd0);

        // Underflow pop.
        do_pop(20'h00000, 3'd6, 4'd0);

        // Replace-top.
        do_push(20'h00AAA, 3'd7, 4'd1);
        slot_on();
        push_req = 1'b1; pop_req = 1'b1; push_val = 20'h00BBB;
        tick();
        push_req = 1'b0; pop_req = 1'b0;
        slot_off();
        chk("rt_pop_valid", {31'd0, pop_valid}, 32'd1);
        chk("rt_push_ack", {31'd0, push_ack}, 32'd1);
        chk("rt_pop_val", {12'd0, pop_val}, 32'h00AAA);
        chk("rt_no_busy", {31'd0, busy}, 32'd0);
        chk("rt_ptr", {29'd0, rstk_ptr}, 32'd7);
        chk("rt_depth", {28'd0, depth}, 32'd1);
        tick();
        chk("rt_strobe_width", {30'd0, pop_valid, push_ack}, 32'd0);
        dbg_read(3'd7, 20'h00BBB);

        // Bus stall blocks the slot entirely.
        slot_on();
        bus_busy = 1'b1;
        push_req = 1'b1; pop_req = 1'b1; push_val = 20'h00CCC;
        tick();
        chk("stall_strobes", {30'd0, pop_valid, push_ack}, 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd0);
        tick();
        push_req = 1'b0; pop_req = 1'b0; bus_busy = 1'b0;
        slot_off();
        chk("stall_ptr", {29'd0, rstk_ptr}, 32'd7);
        chk("stall_depth", {28'd0, depth}, 32'd1);
        chk("stall_pop_val", {12'd0, pop_val}, 32'h00AAA);
        dbg_read(3'd7, 20'h00BBB);

        // Debugger write contends with a decoder pop; the pop goes first.
        slot_on();
        pop_req = 1'b1;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_ptr = 3'd3; dbg_wdata = 20'hFFFFF;
        tick();
        pop_req = 1'b0;
        slot_off();
        chk("arb_ack_a", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("arb_pop_valid", {31'd0, pop_valid}, 32'd1);
        chk("arb_pop_val", {12'd0, pop_val}, 32'h00BBB);
        chk("arb_ack_b", {31'd0, dbg_ack}, 32'd0);
        tick();
        dbg_req = 1'b0; dbg_wr = 1'b0;
        chk("arb_ack_c", {31'd0, dbg_ack}, 32'd1);
        chk("arb_ptr", {29'd0, rstk_ptr}, 32'd6);
        chk("arb_depth", {28'd0, depth}, 32'd0);
        tick();
        dbg_read(3'd3, 20'hFFFFF);
        dbg_read(3'd7, 20'h00000);

        // Reset in POP_CLR aborts the pop and restarts INIT.
        do_push(20'h00555, 3'd7, 4'd1);
        slot_on();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        slot_off();
        chk("abort_in_popclr", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_no_valid", {31'd0, pop_valid}, 32'd0);
        chk("abort_ptr", {29'd0, rstk_ptr}, 32'd7);
        chk("abort_depth", {28'd0, depth}, 32'd0);
        chk("abort_pop_val", {12'd0, pop_val}, 32'd0);
        init_check();
        dbg_read(3'd7, 20'h00000);
        dbg_read(3'd3, 20'h00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
